// File: rtl/ram_stream_fifo.sv
// Valid/ready byte FIFO controller around an external 1-cycle-latency dual-port RAM,
// with a 2-entry show-ahead output stage. Optional synchronous flush: RAM_STREAM_FIFO_CLEAR_EN.
module ram_stream_fifo #(
    parameter int AW = 10,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
`ifdef RAM_STREAM_FIFO_CLEAR_EN
    input  logic          i_clear,
`endif
    input  logic          i_wvalid,
    output logic          o_wready,
    input  logic [DW-1:0] i_wdata,
    output logic          o_rvalid,
    input  logic          i_rready,
    output logic [DW-1:0] o_rdata,
    output logic [AW:0]   o_count,
    output logic          o_ram_we,
    output logic [AW-1:0] o_ram_waddr,
    output logic [DW-1:0] o_ram_wdata,
    output logic [AW-1:0] o_ram_raddr,
    input  logic [DW-1:0] i_ram_rdata
);

    localparam int          DEPTH   = 2 ** AW;
    localparam logic [AW:0] C_DEPTH = (AW + 1)'(DEPTH);

    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_ram_cnt;
    logic          r_inflight;
    logic [1:0]    r_out_cnt;
    logic          r_rvalid;
    logic [DW-1:0] r_rdata;
    logic [DW-1:0] r_skid;

    logic          w_clear;
    logic          w_push;
    logic          w_pop;
    logic [2:0]    w_pend;
    logic          w_rd_go;
    logic          w_head_free;
    logic [1:0]    w_out_cnt_nxt;
    logic [AW:0]   w_ram_cnt_nxt;

`ifdef RAM_STREAM_FIFO_CLEAR_EN
    assign w_clear = i_clear;
`else
    assign w_clear = 1'b0;
`endif

    assign o_wready    = (r_ram_cnt != C_DEPTH);
    assign w_push      = i_wvalid & o_wready & ~w_clear;
    assign w_pop       = r_rvalid & i_rready;

    // Occupancy the output stage will have once the current read lands and the pop retires;
    // a new read may only be issued if that leaves room for it.
    assign w_pend      = {1'b0, r_out_cnt} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_rd_go     = (r_ram_cnt != '0) && (w_pend < 3'd2);

    assign w_head_free = (r_out_cnt == 2'd0) || ((r_out_cnt == 2'd1) && w_pop);
    assign w_out_cnt_nxt = r_out_cnt + {1'b0, r_inflight} - {1'b0, w_pop};

    always_comb begin
        w_ram_cnt_nxt = r_ram_cnt;
        case ({w_push, w_rd_go})
            2'b10:   w_ram_cnt_nxt = r_ram_cnt + 1'b1;
            2'b01:   w_ram_cnt_nxt = r_ram_cnt - 1'b1;
            default: w_ram_cnt_nxt = r_ram_cnt;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_ram_cnt  <= '0;
            r_inflight <= 1'b0;
            r_out_cnt  <= 2'd0;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
        end else if (w_clear) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_ram_cnt  <= '0;
            r_inflight <= 1'b0;
            r_out_cnt  <= 2'd0;
            r_rvalid   <= 1'b0;
            r_rdata    <= '0;
        end else begin
            if (w_push)
                r_wptr <= r_wptr + 1'b1;
            if (w_rd_go)
                r_rptr <= r_rptr + 1'b1;
            r_ram_cnt  <= w_ram_cnt_nxt;
            r_inflight <= w_rd_go;
            r_out_cnt  <= w_out_cnt_nxt;
            r_rvalid   <= (w_out_cnt_nxt != 2'd0);
            // Head is refilled from RAM when it frees up, otherwise from the skid on a pop.
            if (r_inflight && w_head_free)
                r_rdata <= i_ram_rdata;
            else if (w_pop && (r_out_cnt == 2'd2))
                r_rdata <= r_skid;
        end
    end

    // Skid contents are only meaningful while r_out_cnt == 2, so it needs no reset.
    always_ff @(posedge clk) begin
        if (r_inflight && !w_head_free)
            r_skid <= i_ram_rdata;
    end

    assign o_rvalid    = r_rvalid;
    assign o_rdata     = r_rdata;
    assign o_count     = r_ram_cnt + {{AW{1'b0}}, r_inflight} + {{(AW - 1){1'b0}}, r_out_cnt};
    assign o_ram_we    = w_push;
    assign o_ram_waddr = r_wptr;
    assign o_ram_wdata = i_wdata;
    assign o_ram_raddr = r_rptr;

endmodule

// File: tb/tb_ram_stream_fifo.sv
// Randomised scoreboard bench for ram_stream_fifo with a behavioural 1024x8 registered-read RAM.
// Exercises the RAM_STREAM_FIFO_CLEAR_EN flush when that macro is defined.
module tb_ram_stream_fifo;
    localparam int AW = 10;
    localparam int DW = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_clear;
    logic          i_wvalid;
    logic          o_wready;
    logic [DW-1:0] i_wdata;
    logic          o_rvalid;
    logic          i_rready;
    logic [DW-1:0] o_rdata;
    logic [AW:0]   o_count;
    logic          o_ram_we;
    logic [AW-1:0] o_ram_waddr;
    logic [DW-1:0] o_ram_wdata;
    logic [AW-1:0] o_ram_raddr;
    logic [DW-1:0] ram_rdata;
    logic [DW-1:0] mem [DEPTH];

    ram_stream_fifo #(.AW(AW), .DW(DW)) dut (
        .clk(clk),
        .rst(rst),
`ifdef RAM_STREAM_FIFO_CLEAR_EN
        .i_clear(i_clear),
`endif
        .i_wvalid(i_wvalid),
        .o_wready(o_wready),
        .i_wdata(i_wdata),
        .o_rvalid(o_rvalid),
        .i_rready(i_rready),
        .o_rdata(o_rdata),
        .o_count(o_count),
        .o_ram_we(o_ram_we),
        .o_ram_waddr(o_ram_waddr),
        .o_ram_wdata(o_ram_wdata),
        .o_ram_raddr(o_ram_raddr),
        .i_ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (o_ram_we)
            mem[o_ram_waddr] <= o_ram_wdata;
        ram_rdata <= mem[o_ram_raddr];
    end

    logic [7:0] model_q[$];
    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_acc    = 0;
    int         n_pops   = 0;
    logic [7:0] last_pop = 8'h00;
    logic [7:0] mon_exp;
    bit         mon_en   = 1'b0;
    bit         chk_stream = 1'b0;
    bit         primed   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    // Monitor: occupancy against the reference queue, and every delivered byte against its head.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            check("count", int'(o_count), model_q.size());
            if (o_rvalid && i_rready) begin
                if (model_q.size() == 0) begin
                    check("pop_from_empty_model", 1, 0);
                end else begin
                    mon_exp = model_q.pop_front();
                    check("data", int'(o_rdata), int'(mon_exp));
                    last_pop = o_rdata;
                    n_pops++;
                end
            end
            if (chk_stream) begin
                if (o_rvalid)
                    primed = 1'b1;
                if (primed)
                    check("stream_rvalid", int'(o_rvalid), 1);
            end
        end
    end

    // One cycle of stimulus; accepted pushes enter the reference queue at the edge, a clear empties it.
    task automatic drive(input logic v, input logic [7:0] d, input logic r);
        logic acc;
        logic clr;
        i_wvalid = v;
        i_wdata  = d;
        i_rready = r;
        @(negedge clk);
        acc = v && o_wready;
        clr = i_clear;
        @(posedge clk);
        if (clr)
            model_q.delete();
        else if (acc) begin
            model_q.push_back(d);
            n_acc++;
        end
        #1;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((model_q.size() != 0) && (k < 1500)) begin
            drive(1'b0, 8'h00, 1'b1);
            k++;
        end
        drive(1'b0, 8'h00, 1'b0);
        check("drained", model_q.size(), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst = 1'b1; i_clear = 1'b0; i_wvalid = 1'b0; i_wdata = '0; i_rready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_wready", int'(o_wready), 1);
        check("rst_count", int'(o_count), 0);
        check("rst_rvalid", int'(o_rvalid), 0);
        check("rst_rdata", int'(o_rdata), 0);
        mon_en = 1'b1;

        // Single byte latency into an empty FIFO.
        drive(1'b1, 8'hA5, 1'b0);
        check("lat_count_c1", int'(o_count), 1);
        check("lat_rvalid_c1", int'(o_rvalid), 0);
        drive(1'b0, 8'h00, 1'b0);
        check("lat_rvalid_c2", int'(o_rvalid), 0);
        drive(1'b0, 8'h00, 1'b0);
        check("lat_rvalid_c3", int'(o_rvalid), 1);
        check("lat_rdata_c3", int'(o_rdata), 8'hA5);
        drive(1'b0, 8'h00, 1'b0);
        check("lat_hold", int'(o_rdata), 8'hA5);
        drain();

        // Continuous stream with the consumer always ready.
        primed = 1'b0;
        chk_stream = 1'b1;
        for (int i = 0; i < 256; i++)
            drive(1'b1, 8'(i), 1'b1);
        chk_stream = 1'b0;
        check("stream_primed", int'(primed), 1);
        drain();

        // Fill to the maximum, check full, pop one and refill.
        n_acc = 0;
        k = 0;
        while ((n_acc < DEPTH + 2) && (k < 1200)) begin
            drive(1'b1, 8'($urandom), 1'b0);
            k++;
        end
        check("fill_accepted", n_acc, DEPTH + 2);
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        check("full_count", int'(o_count), DEPTH + 2);
        check("full_wready", int'(o_wready), 0);
        drive(1'b1, 8'hEE, 1'b0);
        check("full_ignore", int'(o_count), DEPTH + 2);
        drive(1'b0, 8'h00, 1'b1);
        k = 0;
        while (!o_wready && (k < 2)) begin
            drive(1'b0, 8'h00, 1'b0);
            k++;
        end
        check("wready_after_pop", int'(o_wready), 1);
        drive(1'b1, 8'h5A, 1'b0);
        check("refill_count", int'(o_count), DEPTH + 2);
        drain();
        check("refill_last", int'(last_pop), 8'h5A);

        // Random traffic across several pointer wraps.
        n_acc = 0;
        k = 0;
        while ((n_acc < 3000) && (k < 20000)) begin
            drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
            k++;
        end
        check("random_accepted", n_acc, 3000);
        drain();

        // Asynchronous reset in the middle of traffic.
        for (int i = 0; i < 20; i++)
            drive(1'b1, 8'($urandom), 1'($urandom_range(0, 1)));
        i_wvalid = 1'b0; i_rready = 1'b0;
        mon_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("mid_rst_rvalid", int'(o_rvalid), 0);
        check("mid_rst_rdata", int'(o_rdata), 0);
        check("mid_rst_count", int'(o_count), 0);
        check("mid_rst_wready", int'(o_wready), 1);
        model_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        mon_en = 1'b1;
        drive(1'b1, 8'h17, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        check("post_rst_rdata", int'(o_rdata), 8'h17);
        drain();

`ifdef RAM_STREAM_FIFO_CLEAR_EN
        for (int i = 0; i < 5; i++)
            drive(1'b1, 8'(8'h80 + i), 1'b0);
        i_clear = 1'b1;
        drive(1'b1, 8'h99, 1'b0);
        i_clear = 1'b0;
        check("clr_count", int'(o_count), 0);
        check("clr_rvalid", int'(o_rvalid), 0);
        drive(1'b1, 8'h3C, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        check("clr_first_rvalid", int'(o_rvalid), 1);
        check("clr_first_rdata", int'(o_rdata), 8'h3C);
        drain();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
